// File: rtl/ad_cache_mc_pkg.sv
// Shared constants and bank-state encoding for the ADC double-bank cache.
package ad_cache_mc_pkg;

  localparam logic LOW  = 1'b0;
  localparam logic HIGH = 1'b1;

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2,
    READING = 2'd3
  } bank_state_t;

endpackage

// File: rtl/ad_cache_mc_ram.sv
// Simple dual-port cache RAM: one write port, one read port with a registered read.
module ad_cache_ram #(
  parameter int AW = 9,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/ad_cache_mc.sv
// Multi-channel ADC capture cache: serialises strobes into two ping-pong banks read one word at a time.
// Optional feature macro: AD_CHE_DROP_CNT_EN adds the o_drop_cnt dropped-strobe counter.
module ad_cache_mc
  import ad_cache_mc_pkg::*;
#(
  parameter int CH_NUM     = 4,
  parameter int AD_NBIT    = 16,
  parameter int OUT_NBIT   = 16,
  parameter int BANK_DEPTH = 256,
  parameter int SP_START   = 0,
  parameter int SP_NUM     = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_en,
  input  logic                       i_sync,
  input  logic                       i_strobe,
  input  logic [CH_NUM*AD_NBIT-1:0]  i_data,
  input  logic                       i_rd,
  output logic                       o_rdy,
  output logic                       o_rbank,
  output logic [OUT_NBIT-1:0]        o_rdata,
  output logic                       o_rvalid
`ifdef AD_CHE_DROP_CNT_EN
  ,
  output logic [15:0]                o_drop_cnt
`endif
);

  localparam int AW = $clog2(BANK_DEPTH);
  localparam int CW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int IW = $clog2(SP_START + SP_NUM + 1);
  localparam logic [IW-1:0] WIN_LO    = IW'(SP_START);
  localparam logic [IW-1:0] WIN_LEN   = IW'(SP_NUM);
  localparam logic [IW-1:0] IDX_MAX   = '1;
  localparam logic [AW-1:0] ADDR_LAST = AW'(BANK_DEPTH - 1);
  localparam logic [CW-1:0] CH_LAST   = CW'(CH_NUM - 1);

  logic                      r_sync_d, r_cap_en, r_busy, r_wbank, r_rbank, r_rd_d1;
  logic [IW-1:0]             r_idx;
  logic [CW-1:0]             r_ch;
  logic [CH_NUM*AD_NBIT-1:0] r_data;
  logic [AW-1:0]             r_waddr, r_raddr;
  bank_state_t               r_bst   [2];
  bank_state_t               w_bst_n [2];

  logic                      w_sync_edge, w_cap, w_in_win, w_wr, w_ch_last, w_bank_last;
  logic                      w_writable, w_accept, w_rd_go, w_rd_last, w_borrow;
  logic [IW-1:0]             w_idx, w_rel;
  logic signed [AD_NBIT-1:0] w_sample;
  logic [OUT_NBIT-1:0]       w_wdata, w_ram_q;

  // A strobe on the sync edge already belongs to the new frame as index 0.
  assign w_sync_edge = i_sync & ~r_sync_d;
  assign w_idx       = w_sync_edge ? '0 : r_idx;
  assign w_cap       = w_sync_edge ? i_en : r_cap_en;
  assign {w_borrow, w_rel} = {1'b0, w_idx} - {1'b0, WIN_LO};
  assign w_in_win    = w_cap & ~w_borrow & (w_rel < WIN_LEN);

  assign w_wr        = r_busy & ~w_sync_edge;
  assign w_ch_last   = w_wr & (r_ch == CH_LAST);
  assign w_bank_last = w_wr & (r_waddr == ADDR_LAST);
  // A strobe landing on the final word of a bank must go to the other bank.
  assign w_writable  = w_bank_last ? (r_bst[~r_wbank] == FREE)
                                   : (r_bst[r_wbank] == FREE || r_bst[r_wbank] == FILLING);
  assign w_accept    = i_strobe & w_in_win & (~w_wr | w_ch_last) & w_writable;

  assign w_rd_go     = i_rd & (r_bst[r_rbank] == FULL || r_bst[r_rbank] == READING);
  assign w_rd_last   = w_rd_go & (r_raddr == ADDR_LAST);

  assign w_sample    = r_data[AD_NBIT-1:0];
  assign w_wdata     = OUT_NBIT'(w_sample);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync_d <= LOW;
      r_cap_en <= LOW;
      r_idx    <= '0;
      r_busy   <= LOW;
      r_ch     <= '0;
      r_data   <= '0;
      r_waddr  <= '0;
      r_wbank  <= LOW;
    end else begin
      r_sync_d <= i_sync;
      if (w_sync_edge) r_cap_en <= i_en;
      if (i_strobe) r_idx <= (w_idx == IDX_MAX) ? w_idx : w_idx + 1'b1;
      else if (w_sync_edge) r_idx <= '0;
      if (w_accept) begin
        r_data <= i_data;
        r_busy <= HIGH;
        r_ch   <= '0;
      end else if (w_wr) begin
        r_data <= r_data >> AD_NBIT;
        r_ch   <= r_ch + 1'b1;
        if (w_ch_last) r_busy <= LOW;
      end else if (w_sync_edge) begin
        r_busy <= LOW;
      end
      if (w_sync_edge) r_waddr <= '0;
      else if (w_wr) r_waddr <= r_waddr + 1'b1;
      if (w_bank_last) r_wbank <= ~r_wbank;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_raddr  <= '0;
      r_rbank  <= LOW;
      r_rd_d1  <= LOW;
      o_rvalid <= LOW;
      o_rdata  <= '0;
    end else begin
      r_rd_d1  <= w_rd_go;
      o_rvalid <= r_rd_d1;
      if (r_rd_d1) o_rdata <= w_ram_q;
      if (w_rd_go) begin
        r_raddr <= r_raddr + 1'b1;
        if (w_rd_last) r_rbank <= ~r_rbank;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bst[0] <= FREE;
      r_bst[1] <= FREE;
    end else begin
      r_bst <= w_bst_n;
    end
  end

  // Writer and reader never touch the same bank, so both updates can land together.
  always_comb begin
    w_bst_n = r_bst;
    if (w_bank_last) w_bst_n[r_wbank] = FULL;
    else if (r_bst[r_wbank] == FREE) w_bst_n[r_wbank] = FILLING;
    if (w_rd_go) w_bst_n[r_rbank] = w_rd_last ? FREE : READING;
  end

  always_comb begin
    o_rdy   = (r_bst[0] == FULL || r_bst[1] == FULL) &&
              (r_bst[0] != READING && r_bst[1] != READING);
    o_rbank = r_rbank;
  end

`ifdef AD_CHE_DROP_CNT_EN
  logic        w_drop;
  logic [15:0] r_drop_cnt;

  assign w_drop     = i_strobe & w_in_win & ~w_accept;
  assign o_drop_cnt = r_drop_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_drop_cnt <= '0;
    else if (w_sync_edge) r_drop_cnt <= {15'd0, w_drop};
    else if (w_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 1'b1;
  end
`endif

  ad_cache_ram #(
    .AW (AW + 1),
    .DW (OUT_NBIT)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr),
    .i_waddr ({r_wbank, r_waddr}),
    .i_wdata (w_wdata),
    .i_raddr ({r_rbank, r_raddr}),
    .o_rdata (w_ram_q)
  );

endmodule

// File: tb/tb_ad_cache_mc.sv
// Directed self-checking bench for ad_cache_mc (small banks, 12-bit samples, capture window 2..7).
module tb_ad_cache_mc;

  localparam int CH_NUM     = 4;
  localparam int AD_NBIT    = 12;
  localparam int OUT_NBIT   = 16;
  localparam int BANK_DEPTH = 8;
  localparam int SP_START   = 2;
  localparam int SP_NUM     = 6;

  logic                      clk = 1'b0;
  logic                      rst = 1'b0;
  logic                      i_en = 1'b0;
  logic                      i_sync = 1'b0;
  logic                      i_strobe = 1'b0;
  logic [CH_NUM*AD_NBIT-1:0] i_data = '0;
  logic                      i_rd = 1'b0;
  logic                      o_rdy, o_rbank, o_rvalid;
  logic [OUT_NBIT-1:0]       o_rdata;
`ifdef AD_CHE_DROP_CNT_EN
  logic [15:0]               o_drop_cnt;
`endif

  int checks = 0;
  int failures = 0;

  logic        rd_early [8];
  logic        rd_late  [8];
  logic [15:0] rd_words [8];

  ad_cache_mc #(
    .CH_NUM     (CH_NUM),
    .AD_NBIT    (AD_NBIT),
    .OUT_NBIT   (OUT_NBIT),
    .BANK_DEPTH (BANK_DEPTH),
    .SP_START   (SP_START),
    .SP_NUM     (SP_NUM)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_en       (i_en),
    .i_sync     (i_sync),
    .i_strobe   (i_strobe),
    .i_data     (i_data),
    .i_rd       (i_rd),
    .o_rdy      (o_rdy),
    .o_rbank    (o_rbank),
    .o_rdata    (o_rdata),
    .o_rvalid   (o_rvalid)
`ifdef AD_CHE_DROP_CNT_EN
    ,
    .o_drop_cnt (o_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [47:0] pack4(input logic [11:0] c0, input logic [11:0] c1,
                                        input logic [11:0] c2, input logic [11:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  // All stimulus tasks start and end just after a falling edge.
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_sync(input logic en);
    i_en = en;
    i_sync = 1'b1;
    @(negedge clk);
    i_sync = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_strobe(input logic [47:0] d, input int gap);
    i_data = d;
    i_strobe = 1'b1;
    @(negedge clk);
    i_strobe = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic send_dummies();
    send_strobe(pack4(12'hABC, 12'hABC, 12'hABC, 12'hABC), 2);
    send_strobe(pack4(12'hDEF, 12'hDEF, 12'hDEF, 12'hDEF), 2);
  endtask

  task automatic read_bank();
    for (int i = 0; i < 8; i++) begin
      i_rd = 1'b1;
      @(negedge clk);
      i_rd = 1'b0;
      rd_early[i] = o_rvalid;
      @(negedge clk);
      rd_late[i]  = o_rvalid;
      rd_words[i] = o_rdata;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    idle(2);
    checks++;
    if (o_rdy !== 1'b0 || o_rbank !== 1'b0 || o_rvalid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_flags got rdy=%b rbank=%b rvalid=%b want 0/0/0", o_rdy, o_rbank, o_rvalid);
    end
    checks++;
    if (o_rdata !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL reset_rdata got %h want 0000", o_rdata);
    end
`ifdef AD_CHE_DROP_CNT_EN
    checks++;
    if (o_drop_cnt !== 16'd0) begin
      failures++;
      $display("[TB] FAIL reset_drop got %0d want 0", o_drop_cnt);
    end
`endif
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_basic();
    logic [15:0] exp [8];
    exp = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0007, 16'h0008};
    do_sync(1'b1);
    send_dummies();
    send_strobe(pack4(12'h001, 12'h002, 12'h003, 12'h004), 4);
    checks++;
    if (o_rdy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_half_rdy got %b want 0", o_rdy);
    end
    send_strobe(pack4(12'h005, 12'h006, 12'h007, 12'h008), 4);
    idle(3);
    checks++;
    if (o_rdy !== 1'b1 || o_rbank !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_rdy got rdy=%b rbank=%b want 1/0", o_rdy, o_rbank);
    end
    read_bank();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rd_early[i] !== 1'b0 || rd_late[i] !== 1'b1) begin
        failures++;
        $display("[TB] FAIL basic_latency[%0d] got early=%b late=%b want 0/1", i, rd_early[i], rd_late[i]);
      end
      checks++;
      if (rd_words[i] !== exp[i]) begin
        failures++;
        $display("[TB] FAIL basic_word[%0d] got %h want %h", i, rd_words[i], exp[i]);
      end
    end
    checks++;
    if (o_rdy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_drained_rdy got %b want 0", o_rdy);
    end
  endtask

  task automatic test_sign_extend();
    logic [15:0] exp [8];
    exp = '{16'hF800, 16'h07FF, 16'hFFFF, 16'h0001, 16'h0123, 16'hFA00, 16'h0000, 16'h0456};
    do_sync(1'b1);
    send_dummies();
    send_strobe(pack4(12'h800, 12'h7FF, 12'hFFF, 12'h001), 5);
    send_strobe(pack4(12'h123, 12'hA00, 12'h000, 12'h456), 5);
    idle(2);
    checks++;
    if (o_rdy !== 1'b1 || o_rbank !== 1'b1) begin
      failures++;
      $display("[TB] FAIL sext_rdy got rdy=%b rbank=%b want 1/1", o_rdy, o_rbank);
    end
    read_bank();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rd_late[i] !== 1'b1 || rd_words[i] !== exp[i]) begin
        failures++;
        $display("[TB] FAIL sext_word[%0d] got valid=%b data=%h want 1/%h", i, rd_late[i], rd_words[i], exp[i]);
      end
    end
  endtask

  task automatic test_window_and_stall();
    logic [15:0] exp0 [8];
    logic [15:0] exp1 [8];
    logic [15:0] exp2 [8];
    exp0 = '{16'h0010, 16'h0011, 16'h0012, 16'h0013, 16'h0014, 16'h0015, 16'h0016, 16'h0017};
    exp1 = '{16'h0020, 16'h0021, 16'h0022, 16'h0023, 16'h0024, 16'h0025, 16'h0026, 16'h0027};
    exp2 = '{16'h0030, 16'h0031, 16'h0032, 16'h0033, 16'h0034, 16'h0035, 16'h0036, 16'h0037};
    do_sync(1'b1);
    send_dummies();
    send_strobe(pack4(12'h010, 12'h011, 12'h012, 12'h013), 5);
    send_strobe(pack4(12'h014, 12'h015, 12'h016, 12'h017), 5);
    send_strobe(pack4(12'h020, 12'h021, 12'h022, 12'h023), 5);
    send_strobe(pack4(12'h024, 12'h025, 12'h026, 12'h027), 5);
    send_strobe(pack4(12'h0E0, 12'h0E1, 12'h0E2, 12'h0E3), 5);
    send_strobe(pack4(12'h0E4, 12'h0E5, 12'h0E6, 12'h0E7), 5);
`ifdef AD_CHE_DROP_CNT_EN
    checks++;
    if (o_drop_cnt !== 16'd2) begin
      failures++;
      $display("[TB] FAIL stall_drop_in_window got %0d want 2", o_drop_cnt);
    end
`endif
    send_strobe(pack4(12'h0F0, 12'h0F1, 12'h0F2, 12'h0F3), 5);
    send_strobe(pack4(12'h0F4, 12'h0F5, 12'h0F6, 12'h0F7), 5);
`ifdef AD_CHE_DROP_CNT_EN
    checks++;
    if (o_drop_cnt !== 16'd2) begin
      failures++;
      $display("[TB] FAIL drop_past_window got %0d want 2", o_drop_cnt);
    end
`endif
    checks++;
    if (o_rdy !== 1'b1 || o_rbank !== 1'b0) begin
      failures++;
      $display("[TB] FAIL both_full_rdy got rdy=%b rbank=%b want 1/0", o_rdy, o_rbank);
    end
    do_sync(1'b1);
`ifdef AD_CHE_DROP_CNT_EN
    checks++;
    if (o_drop_cnt !== 16'd0) begin
      failures++;
      $display("[TB] FAIL drop_sync_clear got %0d want 0", o_drop_cnt);
    end
`endif
    send_dummies();
    send_strobe(pack4(12'h0C0, 12'h0C1, 12'h0C2, 12'h0C3), 5);
    send_strobe(pack4(12'h0C4, 12'h0C5, 12'h0C6, 12'h0C7), 5);
    send_strobe(pack4(12'h0C8, 12'h0C9, 12'h0CA, 12'h0CB), 5);
`ifdef AD_CHE_DROP_CNT_EN
    checks++;
    if (o_drop_cnt !== 16'd3) begin
      failures++;
      $display("[TB] FAIL drop_three got %0d want 3", o_drop_cnt);
    end
`endif
    read_bank();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rd_late[i] !== 1'b1 || rd_words[i] !== exp0[i]) begin
        failures++;
        $display("[TB] FAIL stall_bank0[%0d] got valid=%b data=%h want 1/%h", i, rd_late[i], rd_words[i], exp0[i]);
      end
    end
    send_strobe(pack4(12'h030, 12'h031, 12'h032, 12'h033), 5);
    send_strobe(pack4(12'h034, 12'h035, 12'h036, 12'h037), 5);
    checks++;
    if (o_rdy !== 1'b1 || o_rbank !== 1'b1) begin
      failures++;
      $display("[TB] FAIL refill_rdy got rdy=%b rbank=%b want 1/1", o_rdy, o_rbank);
    end
    read_bank();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rd_words[i] !== exp1[i]) begin
        failures++;
        $display("[TB] FAIL stall_bank1[%0d] got %h want %h", i, rd_words[i], exp1[i]);
      end
    end
    checks++;
    if (o_rdy !== 1'b1 || o_rbank !== 1'b0) begin
      failures++;
      $display("[TB] FAIL refill_bank0_rdy got rdy=%b rbank=%b want 1/0", o_rdy, o_rbank);
    end
    read_bank();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rd_words[i] !== exp2[i]) begin
        failures++;
        $display("[TB] FAIL refill_bank0[%0d] got %h want %h", i, rd_words[i], exp2[i]);
      end
    end
    checks++;
    if (o_rdy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL stall_drained_rdy got %b want 0", o_rdy);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp [8];
    exp = '{16'h0040, 16'h0041, 16'h0042, 16'h0043, 16'h0048, 16'h0049, 16'h004A, 16'h004B};
    do_sync(1'b1);
    send_dummies();
    send_strobe(pack4(12'h040, 12'h041, 12'h042, 12'h043), 2);
    send_strobe(pack4(12'h044, 12'h045, 12'h046, 12'h047), 2);
    send_strobe(pack4(12'h048, 12'h049, 12'h04A, 12'h04B), 2);
    send_strobe(pack4(12'h04C, 12'h04D, 12'h04E, 12'h04F), 2);
    idle(6);
`ifdef AD_CHE_DROP_CNT_EN
    checks++;
    if (o_drop_cnt !== 16'd2) begin
      failures++;
      $display("[TB] FAIL b2b_drop got %0d want 2", o_drop_cnt);
    end
`endif
    checks++;
    if (o_rdy !== 1'b1 || o_rbank !== 1'b1) begin
      failures++;
      $display("[TB] FAIL b2b_rdy got rdy=%b rbank=%b want 1/1", o_rdy, o_rbank);
    end
    read_bank();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rd_words[i] !== exp[i]) begin
        failures++;
        $display("[TB] FAIL b2b_word[%0d] got %h want %h", i, rd_words[i], exp[i]);
      end
    end
  endtask

  task automatic test_sync_midfill();
    logic [15:0] exp [8];
    exp = '{16'h0060, 16'h0061, 16'h0062, 16'h0063, 16'h0064, 16'h0065, 16'h0066, 16'h0067};
    do_sync(1'b1);
    send_dummies();
    send_strobe(pack4(12'h050, 12'h051, 12'h052, 12'h053), 5);
    checks++;
    if (o_rdy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midfill_partial_rdy got %b want 0", o_rdy);
    end
    do_sync(1'b1);
    send_dummies();
    send_strobe(pack4(12'h060, 12'h061, 12'h062, 12'h063), 5);
    send_strobe(pack4(12'h064, 12'h065, 12'h066, 12'h067), 5);
    checks++;
    if (o_rdy !== 1'b1 || o_rbank !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midfill_rdy got rdy=%b rbank=%b want 1/0", o_rdy, o_rbank);
    end
    read_bank();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rd_words[i] !== exp[i]) begin
        failures++;
        $display("[TB] FAIL midfill_word[%0d] got %h want %h", i, rd_words[i], exp[i]);
      end
    end
  endtask

  task automatic test_reset_midread();
    do_sync(1'b1);
    send_dummies();
    send_strobe(pack4(12'h070, 12'h071, 12'h072, 12'h073), 5);
    send_strobe(pack4(12'h074, 12'h075, 12'h076, 12'h077), 5);
    checks++;
    if (o_rdy !== 1'b1 || o_rbank !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midread_rdy got rdy=%b rbank=%b want 1/1", o_rdy, o_rbank);
    end
    i_rd = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (o_rvalid !== 1'b1 || o_rdata !== 16'h0070) begin
      failures++;
      $display("[TB] FAIL midread_first got valid=%b data=%h want 1/0070", o_rvalid, o_rdata);
    end
    i_rd = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (o_rvalid !== 1'b0 || o_rdy !== 1'b0 || o_rbank !== 1'b0 || o_rdata !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL midread_reset got valid=%b rdy=%b rbank=%b data=%h want 0/0/0/0000",
               o_rvalid, o_rdy, o_rbank, o_rdata);
    end
`ifdef AD_CHE_DROP_CNT_EN
    checks++;
    if (o_drop_cnt !== 16'd0) begin
      failures++;
      $display("[TB] FAIL midread_reset_drop got %0d want 0", o_drop_cnt);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (o_rvalid !== 1'b0) begin
        failures++;
        $display("[TB] FAIL post_reset_rvalid[%0d] got %b want 0", i, o_rvalid);
      end
    end
    i_rd = 1'b1;
    @(negedge clk);
    i_rd = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (o_rvalid !== 1'b0 || o_rdata !== 16'h0000) begin
        failures++;
        $display("[TB] FAIL ignored_read[%0d] got valid=%b data=%h want 0/0000", i, o_rvalid, o_rdata);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sign_extend();
    test_window_and_stall();
    test_back_to_back();
    test_sync_midfill();
    test_reset_midread();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
